// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU operation decode plus iterative M-extension unit.
// Build option: define ALU_MD_EARLY_OUT_EN to bypass CALC/FIX on special cases.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   in_valid/in_ready issue handshake (ready only in IDLE)
//   Funct7/Funct3     instruction function fields
//   ALUOp             00 ld/st, 01 branch, 10 R-type, 11 reserved
//   rs1_data/rs2_data operands, used by M ops only
//   ALU_ctrl_out      registered 5-bit operation code
//   out_valid         one-cycle completion pulse
//   md_sel            result comes from md_result
//   md_result         M-extension result
//   md_busy           high in CALC and FIX
module alu_ctrl_md #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [1:0]      ALUOp,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [4:0]      ALU_ctrl_out,
  output logic            out_valid,
  output logic            md_sel,
  output logic [XLEN-1:0] md_result,
  output logic            md_busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] dvd;
  logic [2:0]      op3;
  logic            neg_q;
  logic            neg_r;
  logic            dz;

  logic            accept;
  logic [4:0]      code;
  logic            is_m;

  assign accept = in_valid & in_ready;

  // Operation code decode
  always_comb begin
    code = 5'b00000;
    is_m = 1'b0;
    unique case (ALUOp)
      2'b00: code = 5'b00010;
      2'b01: begin
        unique case (Funct3)
          3'b000:  code = 5'b10110;
          3'b001:  code = 5'b10001;
          3'b100:  code = 5'b10010;
          3'b101:  code = 5'b10011;
          3'b110:  code = 5'b10100;
          3'b111:  code = 5'b10101;
          default: code = 5'b00000;
        endcase
      end
      2'b10: begin
        unique case (1'b1)
          (Funct7 == 7'b0000000): begin
            unique case (Funct3)
              3'b000: code = 5'b00010;
              3'b001: code = 5'b01000;
              3'b010: code = 5'b00111;
              3'b011: code = 5'b01001;
              3'b100: code = 5'b01010;
              3'b101: code = 5'b01011;
              3'b110: code = 5'b01101;
              3'b111: code = 5'b01110;
              default: code = 5'b00000;
            endcase
          end
          (Funct7 == 7'b0100000): begin
            unique case (Funct3)
              3'b000:  code = 5'b00110;
              3'b101:  code = 5'b01100;
              default: code = 5'b00000;
            endcase
          end
          (Funct7 == 7'b0000001): begin
            code = {2'b11, Funct3};
            is_m = 1'b1;
          end
          default: code = 5'b00000;
        endcase
      end
      default: code = 5'b00000;
    endcase
  end

  // Operand signedness: MULH, MULHSU, DIV, REM treat rs1 as signed;
  // MULH, DIV, REM treat rs2 as signed. MUL low half is sign-agnostic.
  logic            sa_en;
  logic            sb_en;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  always_comb begin
    sa_en = 1'b0;
    sb_en = 1'b0;
    unique case (Funct3)
      3'b001: begin sa_en = 1'b1; sb_en = 1'b1; end
      3'b010: sa_en = 1'b1;
      3'b100: begin sa_en = 1'b1; sb_en = 1'b1; end
      3'b110: begin sa_en = 1'b1; sb_en = 1'b1; end
      default: begin sa_en = 1'b0; sb_en = 1'b0; end
    endcase
  end

  assign neg_a = sa_en & rs1_data[XLEN-1];
  assign neg_b = sb_en & rs2_data[XLEN-1];
  assign mag_a = neg_a ? -rs1_data : rs1_data;
  assign mag_b = neg_b ? -rs2_data : rs2_data;

  // Iteration step. Multiply: {hi,lo} is the product register with
  // the multiplier shifting out of lo. Divide: hi is the partial
  // remainder, lo the dividend shifting out / quotient shifting in.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_tr;

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  assign div_sh  = {hi, lo[XLEN-1]};
  assign div_tr  = div_sh - {1'b0, opb};

  // Sign fix-up and half/quotient/remainder selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod  = neg_q ? -{hi, lo} : {hi, lo};
    q_fix = neg_q ? -lo : lo;
    r_fix = neg_r ? -hi : hi;
    if (dz) begin
      q_fix = ONES;
      r_fix = dvd;
    end
    if (op3[2]) begin
      fix_res = op3[1] ? r_fix : q_fix;
    end else begin
      fix_res = (op3[1:0] == 2'b00) ? prod[XLEN-1:0]
                                    : prod[2*XLEN-1:XLEN];
    end
  end

`ifdef ALU_MD_EARLY_OUT_EN
  // Results that need no iteration, decided from the raw operands
  logic            eo_dz;
  logic            eo_ov;
  logic            eo_mz;
  logic            eo_hit;
  logic [XLEN-1:0] eo_res;

  assign eo_dz = Funct3[2] & (rs2_data == '0);
  assign eo_ov = Funct3[2] & ~Funct3[0] &
                 (rs1_data == MIN) & (rs2_data == ONES);
  assign eo_mz = ~Funct3[2] &
                 ((rs1_data == '0) | (rs2_data == '0));
  assign eo_hit = is_m & (eo_dz | eo_ov | eo_mz);

  always_comb begin
    eo_res = '0;
    if (eo_dz) begin
      eo_res = Funct3[1] ? rs1_data : ONES;
    end else if (eo_ov) begin
      eo_res = Funct3[1] ? '0 : MIN;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      opb          <= '0;
      dvd          <= '0;
      op3          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz           <= 1'b0;
      in_ready     <= 1'b1;
      ALU_ctrl_out <= '0;
      out_valid    <= 1'b0;
      md_sel       <= 1'b0;
      md_result    <= '0;
      md_busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          out_valid <= 1'b0;
          md_sel    <= 1'b0;
          if (accept) begin
            ALU_ctrl_out <= code;
            if (!is_m) begin
              out_valid <= 1'b1;
            end else begin
              in_ready <= 1'b0;
`ifdef ALU_MD_EARLY_OUT_EN
              if (eo_hit) begin
                state     <= DONE;
                md_result <= eo_res;
                out_valid <= 1'b1;
                md_sel    <= 1'b1;
              end else
`endif
              begin
                state   <= CALC;
                md_busy <= 1'b1;
                cnt     <= CW'(XLEN);
                hi      <= '0;
                lo      <= mag_a;
                opb     <= mag_b;
                dvd     <= rs1_data;
                op3     <= Funct3;
                neg_q   <= neg_a ^ neg_b;
                neg_r   <= neg_a;
                dz      <= (rs2_data == '0);
              end
            end
          end
        end
        CALC: begin
          if (op3[2]) begin
            if (!div_tr[XLEN]) begin
              hi <= div_tr[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= div_sh[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          md_result <= fix_res;
          out_valid <= 1'b1;
          md_sel    <= 1'b1;
          md_busy   <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          out_valid <= 1'b0;
          md_sel    <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
